// File: rtl/sdram_vga_reader.sv
// Pixel-clock reader for the SDRAM frame buffer: drains the read FIFO in step with a
// VGA raster and drives sync, data-enable and RGB565 pixels through a 2-stage pipeline.
module sdram_vga_reader #(
  parameter int H_ACTIVE    = 640,
  parameter int H_FP        = 16,
  parameter int H_SYNC      = 96,
  parameter int H_BP        = 48,
  parameter int V_ACTIVE    = 480,
  parameter int V_FP        = 10,
  parameter int V_SYNC      = 2,
  parameter int V_BP        = 33,
  parameter int START_LEVEL = 512,
  parameter bit SYNC_POL    = 1'b0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [10:0] fifo_rusedw,
  input  logic [15:0] fifo_rdata,
  output logic        fifo_rreq,
  output logic        vga_hs,
  output logic        vga_vs,
  output logic        vga_de,
  output logic [15:0] vga_rgb,
  output logic        frame_start,
  output logic        underflow
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HW      = $clog2(H_TOTAL);
  localparam int VW      = $clog2(V_TOTAL);

  localparam logic [HW-1:0] H_ACT_END  = HW'(H_ACTIVE);
  localparam logic [HW-1:0] H_SYNC_BEG = HW'(H_ACTIVE + H_FP);
  localparam logic [HW-1:0] H_SYNC_END = HW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [HW-1:0] H_LAST     = HW'(H_TOTAL - 1);
  localparam logic [VW-1:0] V_ACT_END  = VW'(V_ACTIVE);
  localparam logic [VW-1:0] V_SYNC_BEG = VW'(V_ACTIVE + V_FP);
  localparam logic [VW-1:0] V_SYNC_END = VW'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [VW-1:0] V_LAST     = VW'(V_TOTAL - 1);
  localparam logic [10:0]   START_WORDS = 11'(START_LEVEL);

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_RUN  = 1'b1;

  logic [0:0]    state;
  logic [HW-1:0] h_cnt;
  logic [VW-1:0] v_cnt;

  logic run, active, hs_on, vs_on, origin, starved;

  assign run     = (state == S_RUN);
  assign active  = (h_cnt < H_ACT_END) && (v_cnt < V_ACT_END);
  assign hs_on   = (h_cnt >= H_SYNC_BEG) && (h_cnt < H_SYNC_END);
  assign vs_on   = (v_cnt >= V_SYNC_BEG) && (v_cnt < V_SYNC_END);
  assign origin  = (h_cnt == '0) && (v_cnt == '0);
  assign starved = (fifo_rusedw == '0);

  assign fifo_rreq = run && active && !starved;

  // NOTE: every clocked block uses non-blocking assignments so all registers
  // sample the pre-edge values and the pipeline stages stay one cycle apart.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (!run) begin
      h_cnt <= '0;
      v_cnt <= '0;
      if (fifo_rusedw >= START_WORDS) state <= S_RUN;
    end else if (h_cnt == H_LAST) begin
      h_cnt <= '0;
      v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + 1'b1;
    end else begin
      h_cnt <= h_cnt + 1'b1;
    end
  end

  // Stage 1: raster controls wait here while the FIFO produces the read word.
  logic de_d, hs_d, vs_d, fs_d, rd_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      de_d <= 1'b0;
      hs_d <= ~SYNC_POL;
      vs_d <= ~SYNC_POL;
      fs_d <= 1'b0;
      rd_d <= 1'b0;
    end else begin
      de_d <= run && active;
      hs_d <= (run && hs_on) ? SYNC_POL : ~SYNC_POL;
      vs_d <= (run && vs_on) ? SYNC_POL : ~SYNC_POL;
      fs_d <= run && origin;
      rd_d <= fifo_rreq;
    end
  end

  // Stage 2: a starved active pixel is forced black rather than reusing stale FIFO data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vga_de      <= 1'b0;
      vga_hs      <= ~SYNC_POL;
      vga_vs      <= ~SYNC_POL;
      vga_rgb     <= '0;
      frame_start <= 1'b0;
      underflow   <= 1'b0;
    end else begin
      vga_de      <= de_d;
      vga_hs      <= hs_d;
      vga_vs      <= vs_d;
      vga_rgb     <= rd_d ? fifo_rdata : 16'h0000;
      frame_start <= fs_d;
      underflow   <= underflow || (run && active && starved);
    end
  end

endmodule
